ff_add_serial: RTL and testbench



---
 rtl/ff_add_serial_if.sv | 31 +++
 rtl/ff_add_serial.sv | 122 ++++++++++++
 tb/tb_ff_add_serial.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ff_add_serial_if.sv
// ff_add_serial_if
//   Operand/result bundle for the word-serial modular adder.
//   rx_start : single-cycle start strobe; rx_a/rx_b/rx_p are sampled with it
//   rx_a     : addend A (expected A < P)
//   rx_b     : addend B (expected B < P)
//   rx_p     : modulus P (odd, nonzero)
//   tx_busy  : operation in flight
//   tx_done  : result valid, held until the next start or reset
//   tx_a     : result (A + B) mod P, meaningful while tx_done is high
//   master drives the rx_ side; slave (the adder) drives the tx_ side.
interface ff_add_serial_if #(
    parameter int unsigned WIDTH = 256
);
    logic             rx_start;
    logic [WIDTH-1:0] rx_a;
    logic [WIDTH-1:0] rx_b;
    logic [WIDTH-1:0] rx_p;
    logic             tx_busy;
    logic             tx_done;
    logic [WIDTH-1:0] tx_a;

    modport master (
        output rx_start, rx_a, rx_b, rx_p,
        input  tx_busy, tx_done, tx_a
    );

    modport slave (
        input  rx_start, rx_a, rx_b, rx_p,
        output tx_busy, tx_done, tx_a
    );
endinterface

// File: rtl/ff_add_serial.sv
// ff_add_serial
//   Word-serial modular adder: tx_a = (A + B) mod P, LIMB bits per cycle.
//   An ADD pass forms the WIDTH+1-bit sum limb by limb, a SUB pass forms
//   sum - P limb by limb, and FINAL keeps sum - P when the full sum is at
//   least P (carry out of the ADD pass, or no borrow out of the SUB pass).
//   Latency is 2*N+1 cycles from the rx_start edge, N = WIDTH/LIMB.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : ff_add_serial_if slave (rx_start/rx_a/rx_b/rx_p in,
//             tx_busy/tx_done/tx_a out)
module ff_add_serial #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned LIMB  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    ff_add_serial_if.slave   bus
);
    localparam int unsigned N  = WIDTH / LIMB;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, ADD, SUB, FINAL} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx;
    logic             c;
    logic             carry_out;
    logic [WIDTH-1:0] op_a, op_b, op_p;
    logic [WIDTH-1:0] sum, diff;

    int unsigned      base;
    logic [LIMB-1:0]  a_limb, b_limb, p_limb, s_limb;
    logic [LIMB:0]    add_res, sub_res;
    logic             last_limb;

    // Current limb slices and the one-limb add / subtract with c as
    // carry-in (ADD) or borrow-in (SUB); bit LIMB is carry/borrow out.
    always_comb begin
        base      = int'(idx) * LIMB;
        a_limb    = op_a[base +: LIMB];
        b_limb    = op_b[base +: LIMB];
        p_limb    = op_p[base +: LIMB];
        s_limb    = sum[base +: LIMB];
        add_res   = {1'b0, a_limb} + {1'b0, b_limb} + {{LIMB{1'b0}}, c};
        sub_res   = {1'b0, s_limb} - {1'b0, p_limb} - {{LIMB{1'b0}}, c};
        last_limb = (idx == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // A start strobe wins in every state, aborting any operation in flight.
    always_comb begin
        state_n = state;
        if (bus.rx_start) begin
            state_n = ADD;
        end else begin
            case (state)
                IDLE:    state_n = IDLE;
                ADD:     if (last_limb) state_n = SUB;
                SUB:     if (last_limb) state_n = FINAL;
                FINAL:   state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.tx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            c           <= 1'b0;
            carry_out   <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_p        <= '0;
            sum         <= '0;
            diff        <= '0;
            bus.tx_a    <= '0;
            bus.tx_done <= 1'b0;
        end else begin
            case (state)
                ADD: begin
                    sum[base +: LIMB] <= add_res[LIMB-1:0];
                    if (last_limb) begin
                        carry_out <= add_res[LIMB];
                        c         <= 1'b0;
                        idx       <= '0;
                    end else begin
                        c         <= add_res[LIMB];
                        idx       <= idx + IW'(1);
                    end
                end
                SUB: begin
                    diff[base +: LIMB] <= sub_res[LIMB-1:0];
                    c                  <= sub_res[LIMB];
                    idx                <= last_limb ? '0 : idx + IW'(1);
                end
                FINAL: begin
                    bus.tx_a    <= (carry_out || !c) ? diff : sum;
                    bus.tx_done <= 1'b1;
                end
                default: ;
            endcase

            // Placed after the state actions so a start coinciding with
            // FINAL still updates tx_a but suppresses tx_done.
            if (bus.rx_start) begin
                op_a        <= bus.rx_a;
                op_b        <= bus.rx_b;
                op_p        <= bus.rx_p;
                idx         <= '0;
                c           <= 1'b0;
                bus.tx_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ff_add_serial.sv
// tb_ff_add_serial
//   Scoreboard bench for ff_add_serial: each start pushes the expected
//   result and completion cycle; a monitor pops on every tx_done rise.
module tb_ff_add_serial;
    localparam int unsigned WIDTH = 256;
    localparam int unsigned N     = 8;
    localparam int unsigned LAT   = 2 * N + 1;
    localparam logic [255:0] P_K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef struct {
        logic [255:0] exp;
        int unsigned  due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    ff_add_serial_if #(.WIDTH(WIDTH)) bus();

    ff_add_serial #(.WIDTH(WIDTH), .LIMB(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Modular sum with a single conditional subtraction of P.
    function automatic logic [255:0] model(input logic [255:0] a, b, p);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return s[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [255:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; the strobe is sampled on the next rising edge.
    task automatic start_op(input logic [255:0] a, b, p);
        exp_t e;
        if (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
        bus.rx_a     = a;
        bus.rx_b     = b;
        bus.rx_p     = p;
        bus.rx_start = 1'b1;
        e.exp = model(a, b, p);
        e.due = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        bus.rx_start = 1'b0;
        bus.rx_a     = rand256();
        bus.rx_b     = rand256();
        bus.rx_p     = rand256();
        check_bit("done_clear_on_start", bus.tx_done, 1'b0);
        check_bit("busy_on_start", bus.tx_busy, 1'b1);
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_outstanding", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compare result and completion cycle on each tx_done rise.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.tx_done && !prev_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got tx_done=1 at cycle %0d expected no result", cyc);
                end else begin
                    e = sb.pop_front();
                    check_vec("result", bus.tx_a, e.exp);
                    check_int("latency_cycle", cyc, e.due);
                end
            end
            prev_done = bus.tx_done;
        end
    end

    initial begin
        int unsigned  d;
        logic [255:0] p, a, b;

        reset_n      = 1'b0;
        bus.rx_start = 1'b0;
        bus.rx_a     = '0;
        bus.rx_b     = '0;
        bus.rx_p     = '0;
        repeat (3) @(negedge clk);
        check_bit("reset_busy", bus.tx_busy, 1'b0);
        check_bit("reset_done", bus.tx_done, 1'b0);
        check_vec("reset_tx_a", bus.tx_a, '0);

        // First start on the first rising edge with reset released.
        reset_n = 1'b1;
        start_op(256'd1, 256'd2, P_K1);
        d = cyc + LAT;
        while (cyc < d - 1) @(negedge clk);
        check_bit("busy_before_final", bus.tx_busy, 1'b1);
        check_bit("done_before_final", bus.tx_done, 1'b0);
        @(negedge clk);
        check_bit("busy_after_final", bus.tx_busy, 1'b0);
        check_bit("done_after_final", bus.tx_done, 1'b1);
        drain(40);

        start_op(P_K1 - 1, 256'd1, P_K1);          drain(40);
        start_op(P_K1 - 1, P_K1 - 1, P_K1);        drain(40);
        start_op(P_K1 - 2, 256'd1, P_K1);          drain(40);
        start_op(256'hFFFF_FFFF, 256'd1, P_K1);    drain(40);

        // Abort: second start six edges after the first.
        start_op(256'd5, 256'd6, P_K1);
        repeat (5) @(negedge clk);
        start_op(256'd7, 256'd8, P_K1);
        drain(40);

        // Start coinciding with FINAL: tx_a updates, tx_done stays low.
        start_op(256'd10, 256'd20, P_K1);
        d = cyc + LAT;
        while (cyc < d - 1) @(negedge clk);
        start_op(256'd3, 256'd4, P_K1);
        check_vec("b2b_final_tx_a", bus.tx_a, 256'd30);
        drain(40);

        // Asynchronous reset mid-operation.
        start_op(256'd11, 256'd12, P_K1);
        repeat (9) @(negedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_bit("async_reset_busy", bus.tx_busy, 1'b0);
        check_bit("async_reset_done", bus.tx_done, 1'b0);
        check_vec("async_reset_tx_a", bus.tx_a, '0);
        @(negedge clk);
        reset_n = 1'b1;
        start_op(256'd1, 256'd2, P_K1);
        drain(40);

        // Random operands, moduli and start gaps (short gaps abort).
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       p = P_K1;
                1:       p = rand256() | 256'd1;
                default: p = (rand256() >> $urandom_range(0, 250)) | 256'd1;
            endcase
            a = rand256();
            b = rand256();
            if ($urandom_range(0, 4) != 0) begin
                a = a % p;
                b = b % p;
            end
            start_op(a, b, p);
            repeat ($urandom_range(0, 22)) @(negedge clk);
        end
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
